// File: rtl/permute_pipeline_sequencer.sv
// permute_pipeline_sequencer: feeds top/bot jobs into the permutation pipeline and serializes results per top
// Ports:
//   clock, rst                      clock and synchronous active-low reset
//   top_valid/top_ready/top_mbf/top_bot_count   top job input
//   bot_valid/bot_ready/bot_mbf     bot stream input
//   pipe_ivalid/pipe_oready/pipe_start_new_top/pipe_bot_a/pipe_bot_b   beats to pipeline
//   pipe_ovalid/pipe_iready/pipe_result_a/pipe_result_b                results from pipeline
//   res_valid/res_ready/res_data/res_is_top/res_last                   serialized result words
//   in_flight                       beats issued but not yet returned
module permute_pipeline_sequencer #(
   parameter int MAX_IN_FLIGHT = 512,
   parameter int MAX_TOPS      = 8,
   parameter int COUNT_W       = 16
) (
   input  logic                               clock,
   input  logic                               rst,
   input  logic                               top_valid,
   output logic                               top_ready,
   input  logic [127:0]                       top_mbf,
   input  logic [COUNT_W-1:0]                 top_bot_count,
   input  logic                               bot_valid,
   output logic                               bot_ready,
   input  logic [127:0]                       bot_mbf,
   output logic                               pipe_ivalid,
   input  logic                               pipe_oready,
   output logic                               pipe_start_new_top,
   output logic [127:0]                       pipe_bot_a,
   output logic [127:0]                       pipe_bot_b,
   input  logic                               pipe_ovalid,
   output logic                               pipe_iready,
   input  logic [63:0]                        pipe_result_a,
   input  logic [63:0]                        pipe_result_b,
   output logic                               res_valid,
   input  logic                               res_ready,
   output logic [63:0]                        res_data,
   output logic                               res_is_top,
   output logic                               res_last,
   output logic [$clog2(MAX_IN_FLIGHT+1)-1:0] in_flight
);
   localparam int CW = $clog2(MAX_IN_FLIGHT + 1);
   localparam int PW = (MAX_TOPS > 1) ? $clog2(MAX_TOPS) : 1;
   localparam int FW = $clog2(MAX_TOPS + 1);

   typedef enum logic [1:0] {I_IDLE, I_TOP, I_BOTS} inState_t;
   typedef enum logic [1:0] {O_IDLE, O_TOP, O_BOTS} outState_t;

   inState_t inState, inNext;
   outState_t outState, outNext;
   logic [127:0] topMbf, laneA, laneB;
   logic [COUNT_W-1:0] remIn, remOut;
   logic [COUNT_W-1:0] tagMem [MAX_TOPS];
   logic [PW-1:0] wrPtr, rdPtr;
   logic [FW-1:0] tagCnt;
   logic [CW-1:0] inFlight;
   logic [1:0] pairCnt, need;
   logic [63:0] skA, skB;
   logic skValid, skPhase;
   logic tagFull, tagEmpty, creditOk, pairFull;
   logic topFire, botFire, pipeFire, getBeat, resFire, wordLast, drainDone, tagPop;

   assign tagFull   = tagCnt == FW'(MAX_TOPS);
   assign tagEmpty  = tagCnt == '0;
   assign creditOk  = inFlight < CW'(MAX_IN_FLIGHT);
   assign need      = remIn >= COUNT_W'(2) ? 2'd2 : 2'd1;
   assign pairFull  = pairCnt == need;
   assign topFire   = top_valid && top_ready;
   assign botFire   = bot_valid && bot_ready;
   assign pipeFire  = pipe_ivalid && pipe_oready;
   assign in_flight = rst ? inFlight : '0;

   // Bot ready bypasses a full pair while it is being handed off, so a new
   // pair starts filling in the same cycle, unless that beat is the last one.
   always_comb begin
      inNext = inState;
      top_ready = 1'b0;
      bot_ready = 1'b0;
      pipe_ivalid = 1'b0;
      pipe_start_new_top = 1'b0;
      pipe_bot_a = '0;
      pipe_bot_b = '0;
      if (rst) begin
         case (inState)
            I_IDLE: begin
               top_ready = !tagFull;
               if (top_valid && !tagFull) inNext = I_TOP;
            end
            I_TOP: begin
               pipe_ivalid = creditOk;
               pipe_start_new_top = 1'b1;
               pipe_bot_a = topMbf;
               if (creditOk && pipe_oready) inNext = remIn == '0 ? I_IDLE : I_BOTS;
            end
            I_BOTS: begin
               pipe_ivalid = pairFull && creditOk;
               pipe_bot_a = laneA;
               pipe_bot_b = laneB;
               bot_ready = !pairFull || (pipe_ivalid && pipe_oready && remIn > COUNT_W'(need));
               if (pipe_ivalid && pipe_oready && remIn == COUNT_W'(need)) inNext = I_IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         inState <= I_IDLE;
         topMbf <= '0;
         remIn <= '0;
         laneA <= '0;
         laneB <= '0;
         pairCnt <= '0;
      end else begin
         inState <= inNext;
         if (topFire) begin
            topMbf <= top_mbf;
            remIn <= top_bot_count;
         end
         if (pipeFire && inState == I_BOTS) remIn <= remIn - COUNT_W'(need);
         // Lane B is cleared whenever a pair is consumed so an odd tail is padded with zero.
         if (botFire) begin
            if (pairCnt == 2'd1 && !pipeFire) begin
               laneB <= bot_mbf;
               pairCnt <= 2'd2;
            end else begin
               laneA <= bot_mbf;
               laneB <= '0;
               pairCnt <= 2'd1;
            end
         end else if (pipeFire) begin
            laneB <= '0;
            pairCnt <= '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (topFire) tagMem[wrPtr] <= top_bot_count;
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         tagCnt <= '0;
         inFlight <= '0;
      end else begin
         if (topFire) wrPtr <= wrPtr == PW'(MAX_TOPS - 1) ? '0 : wrPtr + 1'b1;
         if (tagPop) rdPtr <= rdPtr == PW'(MAX_TOPS - 1) ? '0 : rdPtr + 1'b1;
         tagCnt <= tagCnt + FW'(topFire) - FW'(tagPop);
         inFlight <= inFlight + CW'(pipeFire) - CW'(getBeat);
      end
   end

   // A new result beat may be taken while the last word of the held beat drains,
   // but never across a top boundary, since the next top must be peeked first.
   assign wordLast    = outState == O_TOP ? remOut == '0 : remOut == COUNT_W'(1);
   assign drainDone   = outState == O_TOP || skPhase || remOut == COUNT_W'(1);
   assign res_valid   = rst && skValid;
   assign res_data    = res_valid ? (skPhase ? skB : skA) : '0;
   assign res_is_top  = res_valid && outState == O_TOP;
   assign res_last    = res_valid && wordLast;
   assign resFire     = res_valid && res_ready;
   assign tagPop      = resFire && wordLast;
   assign pipe_iready = rst && outState != O_IDLE && inFlight != '0 && (!skValid || (resFire && drainDone && !wordLast));
   assign getBeat     = pipe_ovalid && pipe_iready;

   always_comb begin
      outNext = (outState == O_IDLE && !tagEmpty) ? O_TOP :
                (outState == O_TOP && resFire) ? (wordLast ? O_IDLE : O_BOTS) :
                (outState == O_BOTS && tagPop) ? O_IDLE : outState;
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         outState <= O_IDLE;
         remOut <= '0;
         skA <= '0;
         skB <= '0;
         skValid <= 1'b0;
         skPhase <= 1'b0;
      end else begin
         outState <= outNext;
         if (outState == O_IDLE && !tagEmpty) remOut <= tagMem[rdPtr];
         else if (outState == O_BOTS && resFire) remOut <= remOut - 1'b1;
         if (getBeat) begin
            skA <= pipe_result_a;
            skB <= pipe_result_b;
            skValid <= 1'b1;
            skPhase <= 1'b0;
         end else if (resFire && drainDone) begin
            skValid <= 1'b0;
         end else if (resFire) begin
            skPhase <= 1'b1;
         end
      end
   end

   resultNeedsCredit: assert property (@(posedge clock) disable iff (!rst) !(pipe_ovalid && inFlight == '0));
endmodule
